// File: rtl/addsub_pkg.sv
// Shared constants for the serial add/subtract unit: op codes, FSM states,
// and the counter-width helper.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/addsub_cell.sv
// One-bit full add/subtract cell; mode selects carry (add) or borrow (sub).
module addsub_cell
  import addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  input  logic mode,
  output logic s_c,
  output logic co_c
);

  assign s_c  = x ^ y ^ c;
  assign co_c = (mode == OP_SUB) ? ((~x & y) | (c & ~(x ^ y)))
                                 : ((x & y) | (c & (x ^ y)));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's-complement add/subtract, LSB first, DIGIT bits per clock.
// Optional SERIAL_ADDSUB_CIN_EN adds a cin port used as the initial carry/borrow.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = clog2(N);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("serial_addsub: WIDTH must be >= 2");
    end
    if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_addsub: DIGIT must divide WIDTH");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d, c_q, c_d;
  logic               cout_q, cout_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic [DIGIT-1:0]   sum;
  logic [DIGIT:0]     chain;
  logic [WIDTH-1:0]   res_shift;
  logic               accept, last, cin_init, ovf_calc;

`ifdef SERIAL_ADDSUB_CIN_EN
  assign cin_init = cin;
`else
  assign cin_init = 1'b0;
`endif

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last   = (state_q == ST_RUN) && (cnt_q == CNT_W'(N - 1));

  assign chain[0] = c_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    addsub_cell u_cell (
      .x   (a_q[i]),
      .y   (b_q[i]),
      .c   (chain[i]),
      .mode(op_q),
      .s_c (sum[i]),
      .co_c(chain[i+1])
    );
  end

  // New digit enters at the MSB end; wide shift keeps DIGIT == WIDTH legal.
  assign res_shift = WIDTH'({sum, res_q} >> DIGIT);

  // In the final digit the top cell sees the operand sign bits.
  assign ovf_calc = (op_q == OP_SUB)
                  ? ((a_q[DIGIT-1] != b_q[DIGIT-1]) && (sum[DIGIT-1] != a_q[DIGIT-1]))
                  : ((a_q[DIGIT-1] == b_q[DIGIT-1]) && (sum[DIGIT-1] != a_q[DIGIT-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      op_d  = op;
      c_d   = cin_init;
      cnt_d = '0;
      res_d = '0;
    end else if (state_q == ST_RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      c_d   = chain[DIGIT];
      cnt_d = cnt_q + CNT_W'(1);
      res_d = res_shift;
      if (last) begin
        result_d = res_shift;
        cout_d   = chain[DIGIT];
        ovf_d    = ovf_calc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised self-checking bench for serial_addsub (DIGIT=1 and DIGIT=4 instances)
// against an integer-arithmetic reference model.
module tb_serial_addsub;

  logic       clk, rst, start, op, cin, sel;
  logic [7:0] a, b;
  logic       busy1, done1, cout1, ovf1, busy4, done4, cout4, ovf4;
  logic [7:0] result1, result4;
  logic       busy_s, done_s, cout_s, ovf_s;
  logic [7:0] result_s;
  int         n_tests, n_fail;

`ifdef SERIAL_ADDSUB_CIN_EN
  localparam bit HAS_CIN = 1'b1;
`else
  localparam bit HAS_CIN = 1'b0;
`endif

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start & ~sel), .op(op), .a(a), .b(b),
`ifdef SERIAL_ADDSUB_CIN_EN
    .cin(cin),
`endif
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start & sel), .op(op), .a(a), .b(b),
`ifdef SERIAL_ADDSUB_CIN_EN
    .cin(cin),
`endif
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
  );

  assign busy_s   = sel ? busy4   : busy1;
  assign done_s   = sel ? done4   : done1;
  assign result_s = sel ? result4 : result1;
  assign cout_s   = sel ? cout4   : cout1;
  assign ovf_s    = sel ? ovf4    : ovf1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_op(input logic o, input logic [7:0] aa, input logic [7:0] bb,
                                 input logic ci, output logic [7:0] r, output logic co,
                                 output logic ov);
    int ua, ub, sa, sb, full, sfull;
    ua = int'(aa);
    ub = int'(bb);
    sa = int'($signed(aa));
    sb = int'($signed(bb));
    if (o == 1'b0) begin
      full  = ua + ub + int'(ci);
      sfull = sa + sb + int'(ci);
      co    = (full > 255);
    end else begin
      full  = ua - ub - int'(ci);
      sfull = sa - sb - int'(ci);
      co    = (full < 0);
    end
    r  = full[7:0];
    ov = (sfull > 127) || (sfull < -128);
  endfunction

  // Called #1 after a posedge; returns #1 after the edge that raised done (or timeout).
  task automatic do_op(input logic d4, input logic o, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, output logic [7:0] r, output logic co, output logic ov,
                       output int lat, output int busy_n);
    sel = d4; op = o; a = aa; b = bb; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = busy_s ? 1 : 0;
    lat = 0;
    while (!done_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy_s) busy_n++;
    end
    r = result_s; co = cout_s; ov = ovf_s;
  endtask

  task automatic test_reset();
    n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy1); end
    n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done1); end
    n_tests++; if (result1 !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", result1); end
    n_tests++; if (cout1 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout1); end
    n_tests++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf1); end
    n_tests++; if ({busy4, done4, result4} !== 10'd0) begin n_fail++; $display("FAIL reset_d4: got %b%b%h want 0", busy4, done4, result4); end
  endtask

  task automatic test_directed();
    logic       t_op[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] t_a[5]   = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hFF};
    logic [7:0] t_b[5]   = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01};
    logic [7:0] t_r[5]   = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00};
    logic       t_co[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       t_ov[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] r; logic co, ov; int lat, bn;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, t_op[i], t_a[i], t_b[i], 1'b0, r, co, ov, lat, bn);
      n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 8", i, lat); end
      n_tests++; if (bn !== 8) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d want 8", i, bn); end
      n_tests++; if (r !== t_r[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, r, t_r[i]); end
      n_tests++; if (co !== t_co[i]) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, co, t_co[i]); end
      n_tests++; if (ov !== t_ov[i]) begin n_fail++; $display("FAIL dir%0d_ovf: got %b want %b", i, ov, t_ov[i]); end
      @(posedge clk); #1;
      n_tests++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done1); end
    end
  endtask

  task automatic test_digit4();
    logic [7:0] r; logic co, ov; int lat, bn;
    do_op(1'b1, 1'b0, 8'h9C, 8'h64, 1'b0, r, co, ov, lat, bn);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL d4_latency: got %0d want 2", lat); end
    n_tests++; if ({r, co, ov} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL d4_add: got %h/%b/%b want 00/1/0", r, co, ov); end
    @(posedge clk); #1;
    if (HAS_CIN) begin
      do_op(1'b0, 1'b1, 8'h05, 8'h03, 1'b1, r, co, ov, lat, bn);
      n_tests++; if ({r, co} !== {8'h01, 1'b0}) begin n_fail++; $display("FAIL cin_sub: got %h/%b want 01/0", r, co); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] er, r; logic eco, eov; int lat;
    ref_op(1'b0, 8'h21, 8'h42, 1'b0, er, eco, eov);
    sel = 1'b0; op = 1'b0; a = 8'h21; b = 8'h42; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    start = 1'b1; op = 1'b1; a = 8'h10; b = 8'h10;
    @(posedge clk); #1;
    start = 1'b0; lat++;
    while (!done1 && lat < 40) begin @(posedge clk); #1; lat++; end
    r = result1;
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL ign_latency: got %0d want 8", lat); end
    n_tests++; if (r !== er) begin n_fail++; $display("FAIL ign_result: got %h want %h", r, er); end
    @(posedge clk); #1;
    n_tests++; if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL ign_no_queue: got busy/done %b%b want 00", busy1, done1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1, r2, e1, e2; logic c1, c2, o1, o2, ec1, ec2, eo1, eo2; int lat, bn;
    ref_op(1'b1, 8'h90, 8'h20, 1'b0, e1, ec1, eo1);
    ref_op(1'b0, 8'h33, 8'h11, 1'b0, e2, ec2, eo2);
    do_op(1'b0, 1'b1, 8'h90, 8'h20, 1'b0, r1, c1, o1, lat, bn);
    do_op(1'b0, 1'b0, 8'h33, 8'h11, 1'b0, r2, c2, o2, lat, bn);
    n_tests++; if ({r1, c1, o1} !== {e1, ec1, eo1}) begin n_fail++; $display("FAIL b2b_first: got %h/%b/%b want %h/%b/%b", r1, c1, o1, e1, ec1, eo1); end
    n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL b2b_latency: got %0d want 8", lat); end
    n_tests++; if ({r2, c2, o2} !== {e2, ec2, eo2}) begin n_fail++; $display("FAIL b2b_second: got %h/%b/%b want %h/%b/%b", r2, c2, o2, e2, ec2, eo2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] r, er; logic co, ov, eco, eov; int lat, bn; bit seen;
    sel = 1'b0; op = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy1); end
    rst = 1'b1; #1;
    n_tests++; if ({busy1, done1, result1, cout1, ovf1} !== 12'd0) begin
      n_fail++; $display("FAIL rstmid_async_clear: got %b/%b/%h/%b/%b want all 0", busy1, done1, result1, cout1, ovf1);
    end
    @(posedge clk); #1;
    rst = 1'b0; seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done1 || busy1) seen = 1'b1; end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got activity %b want 0", seen); end
    ref_op(1'b1, 8'h44, 8'h45, 1'b0, er, eco, eov);
    do_op(1'b0, 1'b1, 8'h44, 8'h45, 1'b0, r, co, ov, lat, bn);
    n_tests++; if ({r, co, ov, 8'(lat)} !== {er, eco, eov, 8'd8}) begin
      n_fail++; $display("FAIL rstmid_after: got %h/%b/%b lat %0d want %h/%b/%b lat 8", r, co, ov, lat, er, eco, eov);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] r, er, ra, rb; logic co, ov, eco, eov, ro, rc, d4; int lat, bn, exp_lat;
    for (int i = 0; i < 50; i++) begin
      d4 = (i >= 30);
      exp_lat = d4 ? 2 : 8;
      ra = 8'($urandom); rb = 8'($urandom); ro = 1'($urandom);
      rc = HAS_CIN ? 1'($urandom) : 1'b0;
      ref_op(ro, ra, rb, rc, er, eco, eov);
      do_op(d4, ro, ra, rb, rc, r, co, ov, lat, bn);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      n_tests++; if ({r, co, ov} !== {er, eco, eov}) begin
        n_fail++; $display("FAIL rnd%0d op=%b a=%h b=%h cin=%b: got %h/%b/%b want %h/%b/%b", i, ro, ra, rb, rc, r, co, ov, er, eco, eov);
      end
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; sel = 1'b0; op = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed();
    test_digit4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
